calendar_ctrl: RTL and testbench

Single-clock calendar sequencer holding the day, month and year registers. It advances them on a one-cycle day-tick enable, with correct days-per-month handling and rollover into month and year. It also accepts validated date loads over a valid/ready handshake. It sits between the time-of-day counter, which supplies `tick_day`, and the display/alarm logic, which consumes the date and the rollover pulses.

---
 rtl/calendar_ctrl.sv | 155 +++++++++++++++
 tb/tb_calendar_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_ctrl.sv
// Day/month/year sequencer advanced by a one-cycle day tick, with validated date loads over valid/ready.
// Optional CAL_LEAP_YEAR_EN gives February 29 days in Gregorian leap years; otherwise February has 28 days.
module calendar_ctrl #(
  parameter int YEAR_W   = 12,
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2099
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_day,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [4:0]        set_day,
  input  logic [3:0]        set_month,
  input  logic [YEAR_W-1:0] set_year,
  output logic              set_err,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              new_month,
  output logic              new_year
);

  localparam logic [YEAR_W-1:0] YMIN = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

  typedef enum logic [1:0] {RUN, CHECK, APPLY} state_t;

  state_t            state_q;
  logic              pend_q;
  logic [4:0]        day_q, sd_q;
  logic [3:0]        month_q, sm_q;
  logic [YEAR_W-1:0] year_q, sy_q;
  logic              set_err_q, new_month_q, new_year_q;

  logic [4:0]        day_d;
  logic [3:0]        month_d;
  logic [YEAR_W-1:0] year_d;
  logic              roll_m, roll_y;
  logic              leap_cur, leap_sh;
  logic [4:0]        dim_cur, dim_sh;
  logic              sh_ok;

  function automatic logic [4:0] dim_f(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim_f = 5'd30;
      4'd2:                    dim_f = leap ? 5'd29 : 5'd28;
      default:                 dim_f = 5'd31;
    endcase
  endfunction

`ifdef CAL_LEAP_YEAR_EN
  localparam logic [YEAR_W-1:0] Y100 = YEAR_W'(100);
  localparam logic [YEAR_W-1:0] Y400 = YEAR_W'(400);
  assign leap_cur = (year_q[1:0] == 2'b00) &&
                    (((year_q % Y100) != '0) || ((year_q % Y400) == '0));
  assign leap_sh  = (sy_q[1:0] == 2'b00) &&
                    (((sy_q % Y100) != '0) || ((sy_q % Y400) == '0));
`else
  assign leap_cur = 1'b0;
  assign leap_sh  = 1'b0;
`endif

  assign dim_cur = dim_f(month_q, leap_cur);
  assign dim_sh  = dim_f(sm_q, leap_sh);

  // Month range is checked first so a bogus month never selects a meaningful day limit.
  assign sh_ok = (sm_q >= 4'd1) && (sm_q <= 4'd12) &&
                 (sd_q >= 5'd1) && (sd_q <= dim_sh) &&
                 (sy_q >= YMIN) && (sy_q <= YMAX);

  always_comb begin
    day_d   = day_q + 5'd1;
    month_d = month_q;
    year_d  = year_q;
    roll_m  = 1'b0;
    roll_y  = 1'b0;
    if (day_q >= dim_cur) begin
      day_d  = 5'd1;
      roll_m = 1'b1;
      if (month_q < 4'd12) begin
        month_d = month_q + 4'd1;
      end else begin
        month_d = 4'd1;
        roll_y  = 1'b1;
        year_d  = (year_q == YMAX) ? YMIN : year_q + YEAR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      day_q       <= 5'd1;
      month_q     <= 4'd1;
      year_q      <= YMIN;
      sd_q        <= '0;
      sm_q        <= '0;
      sy_q        <= '0;
      set_err_q   <= 1'b0;
      new_month_q <= 1'b0;
      new_year_q  <= 1'b0;
    end else begin
      set_err_q   <= 1'b0;
      new_month_q <= 1'b0;
      new_year_q  <= 1'b0;
      case (state_q)
        RUN: begin
          // A live tick and a tick left pending by a rejected load merge into one advance.
          if (tick_day || pend_q) begin
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            new_month_q <= roll_m;
            new_year_q  <= roll_y;
          end
          pend_q <= 1'b0;
          if (set_valid) begin
            sd_q    <= set_day;
            sm_q    <= set_month;
            sy_q    <= set_year;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          pend_q <= pend_q | tick_day;
          if (sh_ok) begin
            state_q <= APPLY;
          end else begin
            set_err_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        APPLY: begin
          day_q   <= sd_q;
          month_q <= sm_q;
          year_q  <= sy_q;
          pend_q  <= 1'b0;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign set_ready = (state_q == RUN);
  assign set_err   = set_err_q;
  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign new_month = new_month_q;
  assign new_year  = new_year_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Bench for calendar_ctrl: directed scenarios plus randomized ticks/loads against a date-arithmetic model.
module tb_calendar_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_day = 1'b0;
  logic        set_valid = 1'b0;
  logic        set_ready, set_err, new_month, new_year;
  logic [4:0]  set_day = '0;
  logic [3:0]  set_month = '0;
  logic [11:0] set_year = '0;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [11:0] year;

  int vectors = 0;
  int miscompares = 0;
  int md, mm, my;

  typedef struct packed {
    logic r0;
    logic e1_err;
    logic e1_rdy;
    logic e2_err;
    logic e2_rdy;
    logic nm2;
    logic ny2;
  } lobs_t;

  always #5 clk = ~clk;

  calendar_ctrl #(.YEAR_W(12), .YEAR_MIN(2000), .YEAR_MAX(2099)) dut (
    .clk(clk), .rst(rst), .tick_day(tick_day), .set_valid(set_valid), .set_ready(set_ready),
    .set_day(set_day), .set_month(set_month), .set_year(set_year), .set_err(set_err),
    .day(day), .month(month), .year(year), .new_month(new_month), .new_year(new_year)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int mdim(input int m, input int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
`ifdef CAL_LEAP_YEAR_EN
    if (m == 2 && ((y % 4 == 0 && y % 100 != 0) || y % 400 == 0)) return 29;
`endif
    return t[m-1];
  endfunction

  function automatic bit mvalid(input int d, input int m, input int y);
    if (m < 1 || m > 12) return 1'b0;
    if (y < 2000 || y > 2099) return 1'b0;
    return (d >= 1) && (d <= mdim(m, y));
  endfunction

  task automatic m_adv(output bit nm, output bit ny);
    nm = 1'b0;
    ny = 1'b0;
    if (md < mdim(mm, my)) md++;
    else begin
      md = 1;
      nm = 1'b1;
      if (mm < 12) mm++;
      else begin
        mm = 1;
        ny = 1'b1;
        my = (my == 2099) ? 2000 : my + 1;
      end
    end
  endtask

  // Expected observations of one load transaction.
  task automatic m_load(input int d, input int m, input int y, input bit t0, input bit t1,
                        input bit t2, output lobs_t e);
    bit a, b, ok, nm, ny;
    if (t0) m_adv(a, b);
    ok = mvalid(d, m, y);
    nm = 1'b0;
    ny = 1'b0;
    if (ok) begin
      md = d; mm = m; my = y;
    end else if (t1 || t2) begin
      m_adv(nm, ny);
    end
    e = '{r0: 1'b0, e1_err: !ok, e1_rdy: !ok, e2_err: 1'b0, e2_rdy: 1'b1, nm2: nm, ny2: ny};
  endtask

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_day = 1'b1;
    cyc();
    tick_day = 1'b0;
  endtask

  task automatic do_load(input int d, input int m, input int y, input bit t0, input bit t1,
                         input bit t2, output lobs_t o);
    set_valid = 1'b1;
    set_day   = 5'(d);
    set_month = 4'(m);
    set_year  = 12'(y);
    tick_day  = t0;
    cyc();
    o.r0 = set_ready;
    set_valid = 1'b0;
    tick_day  = t1;
    cyc();
    o.e1_err = set_err;
    o.e1_rdy = set_ready;
    tick_day = t2;
    cyc();
    o.e2_err = set_err;
    o.e2_rdy = set_ready;
    o.nm2    = new_month;
    o.ny2    = new_year;
    tick_day = 1'b0;
  endtask

  task automatic set_date(input int d, input int m, input int y);
    lobs_t o, e;
    do_load(d, m, y, 1'b0, 1'b0, 1'b0, o);
    m_load(d, m, y, 1'b0, 1'b0, 1'b0, e);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    md = 1; mm = 1; my = 2000;
    vectors++;
    if ({day, month, year} !== {5'd1, 4'd1, 12'd2000}) begin
      miscompares++;
      $display("FAIL reset_date got %0d/%0d/%0d want 1/1/2000", day, month, year);
    end
    vectors++;
    if ({set_ready, set_err, new_month, new_year} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags rdy/err/nm/ny got %b want 1000",
               {set_ready, set_err, new_month, new_year});
    end
  endtask

  task automatic test_month_rollover();
    bit nm, ny;
    set_date(31, 1, 2000);
    do_tick();
    m_adv(nm, ny);
    vectors++;
    if ({day, month, year} !== {5'd1, 4'd2, 12'd2000}) begin
      miscompares++;
      $display("FAIL jan_roll_date got %0d/%0d/%0d want 1/2/2000", day, month, year);
    end
    vectors++;
    if ({new_month, new_year} !== 2'b10) begin
      miscompares++;
      $display("FAIL jan_roll_pulse nm/ny got %b want 10", {new_month, new_year});
    end
    cyc();
    vectors++;
    if ({new_month, new_year} !== 2'b00) begin
      miscompares++;
      $display("FAIL pulse_width nm/ny got %b want 00", {new_month, new_year});
    end
    set_date(30, 4, 2000);
    do_tick();
    m_adv(nm, ny);
    vectors++;
    if ({day, month, year, new_month} !== {5'd1, 4'd5, 12'd2000, 1'b1}) begin
      miscompares++;
      $display("FAIL apr_roll got %0d/%0d/%0d nm=%b want 1/5/2000 nm=1", day, month, year, new_month);
    end
  endtask

  task automatic test_year_wrap();
    bit nm, ny;
    set_date(31, 12, 2099);
    do_tick();
    m_adv(nm, ny);
    vectors++;
    if ({day, month, year, new_month, new_year} !== {5'd1, 4'd1, 12'd2000, 2'b11}) begin
      miscompares++;
      $display("FAIL year_wrap got %0d/%0d/%0d nm/ny=%b want 1/1/2000 nm/ny=11",
               day, month, year, {new_month, new_year});
    end
  endtask

  task automatic test_leap();
    bit nm, ny;
    lobs_t o, e;
    set_date(28, 2, 2024);
    do_tick();
    m_adv(nm, ny);
    vectors++;
    if ({day, month, year, new_month} !== {5'(md), 4'(mm), 12'(my), nm}) begin
      miscompares++;
      $display("FAIL leap_tick got %0d/%0d/%0d nm=%b want %0d/%0d/%0d nm=%b",
               day, month, year, new_month, md, mm, my, nm);
    end
    do_load(29, 2, 2024, 1'b0, 1'b0, 1'b0, o);
    m_load(29, 2, 2024, 1'b0, 1'b0, 1'b0, e);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL leap_load_obs got %b want %b", o, e);
    end
    vectors++;
    if ({day, month, year} !== {5'(md), 4'(mm), 12'(my)}) begin
      miscompares++;
      $display("FAIL leap_load_date got %0d/%0d/%0d want %0d/%0d/%0d", day, month, year, md, mm, my);
    end
  endtask

  task automatic test_reject();
    int tab[5][3] = '{'{30, 2, 2023}, '{1, 13, 2023}, '{0, 5, 2023}, '{1, 1, 1999}, '{31, 9, 2050}};
    lobs_t o, e;
    set_date(10, 10, 2010);
    foreach (tab[i]) begin
      do_load(tab[i][0], tab[i][1], tab[i][2], 1'b0, 1'b0, 1'b0, o);
      m_load(tab[i][0], tab[i][1], tab[i][2], 1'b0, 1'b0, 1'b0, e);
      vectors++;
      if (o !== e || e.e1_err !== 1'b1) begin
        miscompares++;
        $display("FAIL reject_%0d obs got %b want %b", i, o, e);
      end
      vectors++;
      if ({day, month, year} !== {5'd10, 4'd10, 12'd2010}) begin
        miscompares++;
        $display("FAIL reject_%0d_date got %0d/%0d/%0d want 10/10/2010", i, day, month, year);
      end
    end
  endtask

  task automatic test_tick_in_check();
    lobs_t o, e;
    do_load(15, 6, 2030, 1'b0, 1'b1, 1'b0, o);
    m_load(15, 6, 2030, 1'b0, 1'b1, 1'b0, e);
    vectors++;
    if (o !== e || {day, month, year} !== {5'd15, 4'd6, 12'd2030}) begin
      miscompares++;
      $display("FAIL tick_commit got %b %0d/%0d/%0d want %b 15/6/2030", o, day, month, year, e);
    end
    do_load(31, 4, 2030, 1'b0, 1'b1, 1'b0, o);
    m_load(31, 4, 2030, 1'b0, 1'b1, 1'b0, e);
    vectors++;
    if (o !== e || {day, month, year} !== {5'd16, 4'd6, 12'd2030}) begin
      miscompares++;
      $display("FAIL tick_reject got %b %0d/%0d/%0d want %b 16/6/2030", o, day, month, year, e);
    end
    do_load(31, 4, 2030, 1'b0, 1'b1, 1'b1, o);
    m_load(31, 4, 2030, 1'b0, 1'b1, 1'b1, e);
    vectors++;
    if (o !== e || {day, month, year} !== {5'd17, 4'd6, 12'd2030}) begin
      miscompares++;
      $display("FAIL tick_merge got %b %0d/%0d/%0d want %b 17/6/2030", o, day, month, year, e);
    end
  endtask

  task automatic test_reset_in_check();
    set_date(5, 5, 2005);
    set_valid = 1'b1;
    set_day = 5'd15; set_month = 4'd6; set_year = 12'd2030;
    cyc();
    set_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    md = 1; mm = 1; my = 2000;
    vectors++;
    if ({day, month, year, set_ready, set_err} !== {5'd1, 4'd1, 12'd2000, 2'b10}) begin
      miscompares++;
      $display("FAIL rst_check got %0d/%0d/%0d rdy/err=%b want 1/1/2000 rdy/err=10",
               day, month, year, {set_ready, set_err});
    end
    cyc();
    cyc();
    vectors++;
    if ({day, month, year, set_err} !== {5'd1, 4'd1, 12'd2000, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_drop got %0d/%0d/%0d err=%b want 1/1/2000 err=0", day, month, year, set_err);
    end
  endtask

  task automatic test_back_to_back_random();
    bit nm, ny, t0, t1, t2;
    int d, m, y, n;
    lobs_t o, e;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          do_tick();
          m_adv(nm, ny);
          vectors++;
          if ({day, month, year, new_month, new_year} !== {5'(md), 4'(mm), 12'(my), nm, ny}) begin
            miscompares++;
            $display("FAIL rnd_tick_%0d got %0d/%0d/%0d %b want %0d/%0d/%0d %b",
                     it, day, month, year, {new_month, new_year}, md, mm, my, {nm, ny});
          end
        end
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          d = $urandom_range(0, 31);
          m = $urandom_range(0, 15);
          y = $urandom_range(1995, 2104);
        end else begin
          m = $urandom_range(1, 12);
          y = ($urandom_range(0, 3) == 0) ? 2099 : $urandom_range(2000, 2099);
          d = mdim(m, y) - $urandom_range(0, 2);
        end
        t0 = 1'($urandom_range(0, 1));
        t1 = 1'($urandom_range(0, 1));
        t2 = 1'($urandom_range(0, 1));
        do_load(d, m, y, t0, t1, t2, o);
        m_load(d, m, y, t0, t1, t2, e);
        vectors++;
        if (o !== e || {day, month, year} !== {5'(md), 4'(mm), 12'(my)}) begin
          miscompares++;
          $display("FAIL rnd_load_%0d %0d/%0d/%0d t=%b%b%b got %b %0d/%0d/%0d want %b %0d/%0d/%0d",
                   it, d, m, y, t0, t1, t2, o, day, month, year, e, md, mm, my);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_month_rollover();
    test_year_wrap();
    test_leap();
    test_reject();
    test_tick_in_check();
    test_reset_in_check();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
